// File: rtl/div_seq_if.sv
// Request/response bundle for the sequential divider; the core drives the master side.
// start is a request sampled only while busy=0; done pulses for one cycle with res valid.
interface div_seq_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] res;

   modport master (output start, op, a, b, input busy, done, res);
   modport slave  (input start, op, a, b, output busy, done, res);
endinterface

// File: rtl/div_seq.sv
// Restoring shift-subtract divider for RV32M DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Define DIV_EARLY_OUT_EN to finish divide-by-zero and signed overflow without iterating.
module div_seq #(
   parameter int WIDTH = 32
) (
   input  logic       clk,
   input  logic       reset,
   div_seq_if.slave   bus,
   output logic [1:0] state_dbg
);
   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;
   localparam logic [WIDTH-1:0] ONES = '1;
   localparam logic [WIDTH-1:0] MIN  = {1'b1, {(WIDTH-1){1'b0}}};

   logic [1:0]       state;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] quo, rem, dvsr, a_orig, res_q;
   logic             is_rem, neg_q, neg_r, div0, ovf;

   logic             sgn_in, div0_in, ovf_in;
   logic [WIDTH-1:0] mag_a, mag_b;

   assign sgn_in  = ~bus.op[0];
   assign mag_a   = (sgn_in && bus.a[WIDTH-1]) ? -bus.a : bus.a;
   assign mag_b   = (sgn_in && bus.b[WIDTH-1]) ? -bus.b : bus.b;
   assign div0_in = (bus.b == '0);
   assign ovf_in  = sgn_in && (bus.a == MIN) && (bus.b == ONES);

   // The partial remainder is shifted into WIDTH+1 bits so a large divisor never loses the carry.
   logic [WIDTH:0]   shifted, trial;
   logic             take;
   logic [WIDTH-1:0] rem_next, quo_next;

   assign shifted  = {rem, quo[WIDTH-1]};
   assign trial    = shifted - {1'b0, dvsr};
   assign take     = ~trial[WIDTH];
   assign rem_next = take ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
   assign quo_next = {quo[WIDTH-2:0], take};

   logic [WIDTH-1:0] q_val, r_val, res_calc;

   always_comb begin
      q_val = neg_q ? -quo : quo;
      r_val = neg_r ? -rem : rem;
      if (div0) begin
         q_val = ONES;
         r_val = a_orig;
      end else if (ovf) begin
         q_val = MIN;
         r_val = '0;
      end
      res_calc = is_rem ? r_val : q_val;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= S_IDLE;
         count  <= '0;
         quo    <= '0;
         rem    <= '0;
         dvsr   <= '0;
         a_orig <= '0;
         res_q  <= '0;
         is_rem <= 1'b0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         div0   <= 1'b0;
         ovf    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  is_rem <= bus.op[1];
                  a_orig <= bus.a;
                  quo    <= mag_a;
                  rem    <= '0;
                  dvsr   <= mag_b;
                  neg_q  <= sgn_in & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                  neg_r  <= sgn_in & bus.a[WIDTH-1];
                  div0   <= div0_in;
                  ovf    <= ovf_in;
                  count  <= CW'(WIDTH);
`ifdef DIV_EARLY_OUT_EN
                  state  <= (div0_in || ovf_in) ? S_DONE : S_RUN;
`else
                  state  <= S_RUN;
`endif
               end
            end
            S_RUN: begin
               quo   <= quo_next;
               rem   <= rem_next;
               count <= count - 1'b1;
               if (count == CW'(1)) state <= S_DONE;
            end
            S_DONE: begin
               res_q <= res_calc;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // res is combinational during the done pulse and held in res_q afterwards.
   assign bus.busy  = (state != S_IDLE);
   assign bus.done  = (state == S_DONE);
   assign bus.res   = (state == S_DONE) ? res_calc : res_q;
   assign state_dbg = state;
endmodule
